// File: rtl/seg7_scan_driver_if.sv
// Load/data/display bundle between the BCD stage and the two-digit scan driver.
interface seg7_scan_driver_if;
  logic       load;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       blank_lz;
  logic [6:0] seg;
  logic [1:0] digit_sel;
  logic       frame_done;

  modport master (output load, tens, ones, blank_lz,
                  input  seg, digit_sel, frame_done);
  modport slave  (input  load, tens, ones, blank_lz,
                  output seg, digit_sel, frame_done);
endinterface

// File: rtl/seg7_scan_driver.sv
// Two-digit multiplexed 7-segment driver: show ones, gap, show tens, gap.
// All outputs are registered from the next state so they move with it.
module seg7_scan_driver #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  seg7_scan_driver_if.slave  bus
);
  localparam int CW = $clog2(SCAN_DIV > BLANK_CYC ? SCAN_DIV : BLANK_CYC);
  localparam logic [CW-1:0] SHOW_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(BLANK_CYC - 1);

  localparam logic [1:0] SHOW_O = 2'd0;
  localparam logic [1:0] GAP_O  = 2'd1;
  localparam logic [1:0] SHOW_T = 2'd2;
  localparam logic [1:0] GAP_T  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    tens_q, tens_d, ones_q, ones_d;
  logic [6:0]    seg_q, seg_d;
  logic [1:0]    sel_q, sel_d;
  logic          fd_q, fd_d;

  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'd0:    decode = 7'h3F;
      4'd1:    decode = 7'h06;
      4'd2:    decode = 7'h5B;
      4'd3:    decode = 7'h4F;
      4'd4:    decode = 7'h66;
      4'd5:    decode = 7'h6D;
      4'd6:    decode = 7'h7D;
      4'd7:    decode = 7'h07;
      4'd8:    decode = 7'h7F;
      4'd9:    decode = 7'h6F;
      default: decode = 7'h40;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    case (state_q)
      SHOW_O:  if (cnt_q == SHOW_LAST) state_d = GAP_O;
      GAP_O:   if (cnt_q == GAP_LAST)  state_d = SHOW_T;
      SHOW_T:  if (cnt_q == SHOW_LAST) state_d = GAP_T;
      GAP_T:   if (cnt_q == GAP_LAST)  state_d = SHOW_O;
      default: state_d = GAP_T;
    endcase
    if (state_d != state_q) cnt_d = '0;

    tens_d = bus.load ? bus.tens : tens_q;
    ones_d = bus.load ? bus.ones : ones_q;

    // Display uses the registered digits, so a load shows up one edge later.
    seg_d = 7'h00;
    sel_d = 2'b00;
    case (state_d)
      SHOW_O: begin
        sel_d = 2'b01;
        seg_d = decode(ones_q);
      end
      SHOW_T: if (!(bus.blank_lz && tens_q == 4'd0)) begin
        sel_d = 2'b10;
        seg_d = decode(tens_q);
      end
      default: ;
    endcase
    fd_d = (state_q == GAP_T) && (state_d == SHOW_O);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= GAP_T;
      cnt_q   <= '0;
      tens_q  <= 4'd0;
      ones_q  <= 4'd0;
      seg_q   <= 7'h00;
      sel_q   <= 2'b00;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      seg_q   <= seg_d;
      sel_q   <= sel_d;
      fd_q    <= fd_d;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.digit_sel  = sel_q;
  assign bus.frame_done = fd_q;
endmodule
